// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART RX command assembler.
// Frame = operand bytes (LSB first) followed by one command byte.
package uart_cmd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    S_OPER,
    S_CMD
  } rx_cmd_state_t;

  function automatic int bytes_per_op(input int op_width);
    return op_width / BYTE_W;
  endfunction

endpackage

// File: rtl/uart_rx_cmd_assembler_if.sv
// Byte stream in from UART_rx, committed operands/command out to the ALU.
// master: byte source and result consumer; slave: the assembler.
interface uart_rx_cmd_assembler_if #(
  parameter int OP_WIDTH  = 16,
  parameter int NUM_OPS   = 2,
  parameter int CMD_WIDTH = 3
);
  import uart_cmd_pkg::*;

  logic [BYTE_W-1:0]                rx_data;
  logic                             rx_ready;
  logic [NUM_OPS-1:0][OP_WIDTH-1:0] operands;
  logic [CMD_WIDTH-1:0]             alu_ctrl;
  logic                             output_ready;

  modport master (
    output rx_data, rx_ready,
    input  operands, alu_ctrl, output_ready
  );

  modport slave (
    input  rx_data, rx_ready,
    output operands, alu_ctrl, output_ready
  );

endinterface

// File: rtl/uart_rx_timeout.sv
// Inter-byte watchdog: counts idle cycles while run, reloads on each byte.
// expired is combinational and falls once the owner aborts the frame.
module uart_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !run || reload) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && !reload &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_rx_cmd_assembler.sv
// Collects NUM_OPS operands plus a command byte and commits them atomically.
// Optional inter-byte timeout abort enabled by defining RX_TIMEOUT_EN.
module uart_rx_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int OP_WIDTH       = 16,
  parameter int NUM_OPS        = 2,
  parameter int CMD_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  uart_rx_cmd_assembler_if.slave       rx,
  input  logic                         clear,
  output logic [$clog2(NUM_OPS+1)-1:0] state_id,
  output logic                         busy,
  output logic                         timeout_err
);
  localparam int BPO   = bytes_per_op(OP_WIDTH);
  localparam int SID_W = $clog2(NUM_OPS + 1);
  localparam int OI_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int BI_W  = (BPO > 1) ? $clog2(BPO) : 1;

  if ((OP_WIDTH % BYTE_W) != 0 || OP_WIDTH < BYTE_W) begin : g_bad_opw
    $error("OP_WIDTH must be a nonzero multiple of 8");
  end
  if (NUM_OPS < 1) begin : g_bad_nops
    $error("NUM_OPS must be at least 1");
  end
  if (CMD_WIDTH < 1 || CMD_WIDTH > BYTE_W) begin : g_bad_cmdw
    $error("CMD_WIDTH must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  rx_cmd_state_t                    state, state_n;
  logic [OI_W-1:0]                  op_idx, op_n;
  logic [BI_W-1:0]                  byte_idx, byte_n;
  logic [NUM_OPS-1:0][OP_WIDTH-1:0] shadow, shadow_n;
  logic                             accept, tmo, commit;
  logic                             last_op, last_byte;

  assign accept    = rx.rx_ready && !clear;
  assign last_op   = int'(op_idx) == NUM_OPS - 1;
  assign last_byte = int'(byte_idx) == BPO - 1;

`ifdef RX_TIMEOUT_EN
  uart_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .run    (busy),
    .reload (accept),
    .expired(tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_OPER;
      op_idx          <= '0;
      byte_idx        <= '0;
      shadow          <= '0;
      rx.operands     <= '0;
      rx.alu_ctrl     <= '0;
      rx.output_ready <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_n;
      op_idx          <= op_n;
      byte_idx        <= byte_n;
      shadow          <= shadow_n;
      rx.output_ready <= commit;
      timeout_err     <= tmo && !clear;
      if (commit) begin
        rx.operands <= shadow;
        rx.alu_ctrl <= rx.rx_data[CMD_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_n  = state;
    op_n     = op_idx;
    byte_n   = byte_idx;
    shadow_n = shadow;
    commit   = 1'b0;
    if (clear || tmo) begin
      state_n  = S_OPER;
      op_n     = '0;
      byte_n   = '0;
      shadow_n = '0;
    end else if (accept) begin
      unique case (state)
        S_OPER: begin
          for (int o = 0; o < NUM_OPS; o++)
            for (int b = 0; b < BPO; b++)
              if (int'(op_idx) == o && int'(byte_idx) == b)
                shadow_n[o][b*BYTE_W +: BYTE_W] = rx.rx_data;
          if (last_byte) begin
            byte_n = '0;
            if (last_op) begin
              op_n    = '0;
              state_n = S_CMD;
            end else begin
              op_n = op_idx + OI_W'(1);
            end
          end else begin
            byte_n = byte_idx + BI_W'(1);
          end
        end
        S_CMD: begin
          commit  = 1'b1;
          state_n = S_OPER;
        end
      endcase
    end
  end

  always_comb begin
    state_id = (state == S_CMD) ? SID_W'(NUM_OPS)
                                : SID_W'(op_idx);
    busy     = (state != S_OPER) || (byte_idx != '0) ||
               (op_idx != '0);
  end

endmodule

// File: tb/tb_uart_rx_cmd_assembler.sv
// Directed bench: default 2x16 instance plus a 3x32 back-to-back instance.
// Timeout checks follow RX_TIMEOUT_EN (TIMEOUT_CYCLES=100).
module tb_uart_rx_cmd_assembler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear0 = 1'b0;
  logic clear1 = 1'b0;
  logic [1:0] sid0, sid1;
  logic busy0, busy1, tmo0, tmo1;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_rx_cmd_assembler_if #(
    .OP_WIDTH(16), .NUM_OPS(2), .CMD_WIDTH(3)
  ) b0 ();
  uart_rx_cmd_assembler_if #(
    .OP_WIDTH(32), .NUM_OPS(3), .CMD_WIDTH(3)
  ) b1 ();

  uart_rx_cmd_assembler #(
    .OP_WIDTH(16), .NUM_OPS(2), .CMD_WIDTH(3),
    .TIMEOUT_CYCLES(100)
  ) d0 (
    .clock      (clock),
    .reset      (reset),
    .rx         (b0),
    .clear      (clear0),
    .state_id   (sid0),
    .busy       (busy0),
    .timeout_err(tmo0)
  );

  uart_rx_cmd_assembler #(
    .OP_WIDTH(32), .NUM_OPS(3), .CMD_WIDTH(3),
    .TIMEOUT_CYCLES(100)
  ) d1 (
    .clock      (clock),
    .reset      (reset),
    .rx         (b1),
    .clear      (clear1),
    .state_id   (sid1),
    .busy       (busy1),
    .timeout_err(tmo1)
  );

  typedef struct packed {
    logic [39:0] by;
    logic [31:0] ops;
    logic [2:0]  alu;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] fb [26];

  task automatic chk(input string n,
                     input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send0(input logic [7:0] d);
    b0.rx_data  = d;
    b0.rx_ready = 1'b1;
    tick();
    b0.rx_ready = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d);
    b1.rx_data  = d;
    b1.rx_ready = 1'b1;
    tick();
    b1.rx_ready = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string t);
    logic [39:0] by;
    by = v.by;
    for (int i = 0; i < 5; i++) begin
      send0(by[i*8 +: 8]);
      if (i == 1) chk({t, ".sid1"}, sid0, 1);
      if (i == 3) begin
        chk({t, ".early_rdy"}, b0.output_ready, 0);
        chk({t, ".sid_cmd"}, sid0, 2);
        chk({t, ".busy"}, busy0, 1);
      end
    end
    chk({t, ".rdy"}, b0.output_ready, 1);
    chk({t, ".ops"}, b0.operands, v.ops);
    chk({t, ".alu"}, b0.alu_ctrl, v.alu);
    chk({t, ".sid0"}, sid0, 0);
    chk({t, ".idle"}, busy0, 0);
    tick();
    chk({t, ".rdy_low"}, b0.output_ready, 0);
  endtask

  initial begin
    int pulses;
    int hits;
    vecs[0] = '{by: 40'h02_56_78_12_34,
                ops: 32'h5678_1234, alu: 3'd2};
    vecs[1] = '{by: 40'hFF_FF_FE_80_01,
                ops: 32'hFFFE_8001, alu: 3'd7};
    vecs[2] = '{by: 40'h05_00_BB_00_AA,
                ops: 32'h00BB_00AA, alu: 3'd5};
    vecs[3] = '{by: 40'h0B_DE_AD_BE_EF,
                ops: 32'hDEAD_BEEF, alu: 3'd3};
    fb = '{8'h44, 8'h33, 8'h22, 8'h11,
           8'h88, 8'h77, 8'h66, 8'h55,
           8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h06,
           8'hEF, 8'hBE, 8'hAD, 8'hDE,
           8'h04, 8'h03, 8'h02, 8'h01,
           8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hF9};
    b0.rx_data  = '0;
    b0.rx_ready = 1'b0;
    b1.rx_data  = '0;
    b1.rx_ready = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst.ops", b0.operands, 0);
    chk("rst.alu", b0.alu_ctrl, 0);
    chk("rst.rdy", b0.output_ready, 0);
    chk("rst.sid", sid0, 0);
    chk("rst.busy", busy0, 0);
    chk("rst.tmo", tmo0, 0);
    chk("rst.ops1", b1.operands, 0);

    for (int k = 0; k < 4; k++)
      run_frame(vecs[k], $sformatf("vec%0d", k));

    send0(8'h34);
    send0(8'h12);
    send0(8'h78);
    chk("clr.busy_pre", busy0, 1);
    chk("clr.sid_pre", sid0, 1);
    b0.rx_data  = 8'h56;
    b0.rx_ready = 1'b1;
    clear0      = 1'b1;
    tick();
    b0.rx_ready = 1'b0;
    clear0      = 1'b0;
    chk("clr.busy", busy0, 0);
    chk("clr.sid", sid0, 0);
    chk("clr.ops_hold", b0.operands, 32'hDEAD_BEEF);
    chk("clr.alu_hold", b0.alu_ctrl, 3);
    chk("clr.rdy", b0.output_ready, 0);
    run_frame('{by: 40'h01_44_33_22_11,
                ops: 32'h4433_2211, alu: 3'd1}, "clr.next");

    send0(8'h01);
    send0(8'h02);
`ifdef RX_TIMEOUT_EN
    repeat (99) tick();
    chk("to.err_pre", tmo0, 0);
    chk("to.busy_pre", busy0, 1);
    tick();
    chk("to.err", tmo0, 1);
    chk("to.busy", busy0, 0);
    chk("to.sid", sid0, 0);
    chk("to.rdy", b0.output_ready, 0);
    chk("to.ops_hold", b0.operands, 32'h4433_2211);
    tick();
    chk("to.err_pulse", tmo0, 0);
    send0(8'h01);
    send0(8'h02);
    repeat (99) tick();
    send0(8'h03);
    chk("to.edge_err", tmo0, 0);
    chk("to.edge_busy", busy0, 1);
    tick();
    chk("to.edge_err2", tmo0, 0);
`else
    hits = 0;
    repeat (150) begin
      tick();
      if (tmo0) hits++;
    end
    chk("nto.err_seen", hits, 0);
    chk("nto.busy", busy0, 1);
    chk("nto.sid", sid0, 1);
    send0(8'h03);
`endif
    send0(8'h04);
    send0(8'h05);
    chk("tail.rdy", b0.output_ready, 1);
    chk("tail.ops", b0.operands, 32'h0403_0201);
    chk("tail.alu", b0.alu_ctrl, 5);
    tick();

    send0(8'hAA);
    send0(8'h00);
    send0(8'hBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst.ops", b0.operands, 0);
    chk("mrst.alu", b0.alu_ctrl, 0);
    chk("mrst.rdy", b0.output_ready, 0);
    chk("mrst.sid", sid0, 0);
    chk("mrst.busy", busy0, 0);
    chk("mrst.tmo", tmo0, 0);
    run_frame(vecs[2], "mrst.next");

    pulses = 0;
    for (int i = 0; i < 26; i++) begin
      send1(fb[i]);
      if (b1.output_ready) pulses++;
      if (i == 11) chk("b2b.sid_cmd", sid1, 3);
      if (i == 12) begin
        chk("b2b.rdyA", b1.output_ready, 1);
        chk("b2b.opsA", b1.operands,
            96'h99AABBCC_55667788_11223344);
        chk("b2b.aluA", b1.alu_ctrl, 6);
      end
      if (i == 13) begin
        chk("b2b.rdyA_low", b1.output_ready, 0);
        chk("b2b.opsA_hold", b1.operands,
            96'h99AABBCC_55667788_11223344);
        chk("b2b.busyB", busy1, 1);
      end
    end
    chk("b2b.rdyB", b1.output_ready, 1);
    chk("b2b.opsB", b1.operands,
        96'hCAFEF00D_01020304_DEADBEEF);
    chk("b2b.aluB", b1.alu_ctrl, 1);
    tick();
    if (b1.output_ready) pulses++;
    chk("b2b.pulses", pulses, 2);
    chk("b2b.idle", busy1, 0);
    chk("b2b.tmo", tmo1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
